// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: memory-stage slot fields in, register-file write port out.
// The master side is the memory stage plus register file; the slave side is the WB unit.
interface writeback_stage_if #(
   parameter int XLEN = 64
);
   logic            mem_valid;
   logic            mem_RegWrite;
   logic [1:0]      mem_MemtoReg;
   logic [2:0]      mem_Funct3;
   logic [XLEN-1:0] mem_ALUResult;
   logic [XLEN-1:0] mem_ReadData;
   logic [XLEN-1:0] mem_PCPlus4;
   logic [4:0]      mem_RD;

   logic            RegWrite;
   logic [4:0]      RD;
   logic [XLEN-1:0] WriteData;
   logic            wb_valid;

   modport master (
      output mem_valid, mem_RegWrite, mem_MemtoReg, mem_Funct3,
             mem_ALUResult, mem_ReadData, mem_PCPlus4, mem_RD,
      input  RegWrite, RD, WriteData, wb_valid
   );

   modport slave (
      input  mem_valid, mem_RegWrite, mem_MemtoReg, mem_Funct3,
             mem_ALUResult, mem_ReadData, mem_PCPlus4, mem_RD,
      output RegWrite, RD, WriteData, wb_valid
   );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback unit: load extraction, source select,
// register-file write enable, retired-instruction counter and sticky error flags.
module writeback_stage #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 flush,
   writeback_stage_if.slave     bus,
   output logic [CNT_W-1:0]     retired,
   output logic [1:0]           err_sticky
);

   typedef enum logic [1:0] {
      SRC_ALU  = 2'b00,
      SRC_LOAD = 2'b01,
      SRC_PC4  = 2'b10,
      SRC_RSVD = 2'b11
   } wb_src_e;

   typedef enum logic [2:0] {
      F3_LB   = 3'b000,
      F3_LH   = 3'b001,
      F3_LW   = 3'b010,
      F3_LD   = 3'b011,
      F3_LBU  = 3'b100,
      F3_LHU  = 3'b101,
      F3_LWU  = 3'b110,
      F3_RSVD = 3'b111
   } load_f3_e;

   logic            wb_valid_q;
   logic            wb_reg_write;
   wb_src_e         wb_src;
   load_f3_e        wb_f3;
   logic [XLEN-1:0] wb_alu;
   logic [XLEN-1:0] wb_rdata;
   logic [XLEN-1:0] wb_pc4;
   logic [4:0]      wb_rd;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid_q   <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_src       <= SRC_ALU;
         wb_f3        <= F3_LB;
         wb_alu       <= '0;
         wb_rdata     <= '0;
         wb_pc4       <= '0;
         wb_rd        <= '0;
      end else if (flush) begin
         wb_valid_q   <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_src       <= SRC_ALU;
         wb_f3        <= F3_LB;
         wb_alu       <= '0;
         wb_rdata     <= '0;
         wb_pc4       <= '0;
         wb_rd        <= '0;
      end else if (!stall) begin
         wb_valid_q   <= bus.mem_valid;
         wb_reg_write <= bus.mem_RegWrite;
         wb_src       <= wb_src_e'(bus.mem_MemtoReg);
         wb_f3        <= load_f3_e'(bus.mem_Funct3);
         wb_alu       <= bus.mem_ALUResult;
         wb_rdata     <= bus.mem_ReadData;
         wb_pc4       <= bus.mem_PCPlus4;
         wb_rd        <= bus.mem_RD;
      end
   end

   // Lane selects; misaligned half/word picks are don't-care because the write is suppressed.
   logic [2:0]  off;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] word_sel;

   assign off      = wb_alu[2:0];
   assign byte_sel = wb_rdata[{off, 3'b000} +: 8];
   assign half_sel = wb_rdata[{off[2:1], 4'b0000} +: 16];
   assign word_sel = wb_rdata[{off[2], 5'b00000} +: 32];

   logic [XLEN-1:0] load_data;
   logic            misaligned;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      load_data  = '0;
      misaligned = 1'b0;
      unique case (wb_f3)
         F3_LB:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_LBU: load_data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_LH: begin
            load_data  = {{(XLEN-16){half_sel[15]}}, half_sel};
            misaligned = off[0];
         end
         F3_LHU: begin
            load_data  = {{(XLEN-16){1'b0}}, half_sel};
            misaligned = off[0];
         end
         F3_LW: begin
            load_data  = {{(XLEN-32){word_sel[31]}}, word_sel};
            misaligned = |off[1:0];
         end
         F3_LWU: begin
            load_data  = {{(XLEN-32){1'b0}}, word_sel};
            misaligned = |off[1:0];
         end
         F3_LD: begin
            load_data  = wb_rdata;
            misaligned = |off;
         end
         default: load_data = '0;
      endcase
   end

   logic [XLEN-1:0] write_data;

   always_comb begin
      write_data = '0;
      unique case (wb_src)
         SRC_ALU:  write_data = wb_alu;
         SRC_LOAD: write_data = load_data;
         SRC_PC4:  write_data = wb_pc4;
         default:  write_data = '0;
      endcase
   end

   logic is_load;
   logic err_misaligned;
   logic err_reserved;
   logic bad;
   logic count_en;

   assign is_load        = (wb_src == SRC_LOAD);
   assign err_misaligned = is_load & misaligned;
   assign err_reserved   = (wb_src == SRC_RSVD) | (is_load & (wb_f3 == F3_RSVD));
   assign bad            = err_misaligned | err_reserved;

   // A slot leaves WB when the register advances or when a flush overwrites it.
   assign count_en = wb_valid_q & (flush | ~stall);

   // Built from registers only, so an asynchronous reset drops the write enable at once.
   assign bus.RegWrite  = wb_valid_q & wb_reg_write & (wb_rd != 5'd0) & ~bad;
   assign bus.RD        = wb_rd;
   assign bus.WriteData = write_data;
   assign bus.wb_valid  = wb_valid_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         retired    <= '0;
         err_sticky <= 2'b00;
      end else if (count_en) begin
         retired    <= retired + CNT_W'(1);
         err_sticky <= err_sticky | {err_reserved, err_misaligned};
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed scoreboard bench for writeback_stage: expected WB outputs are queued as each
// slot is presented and popped one posedge later.
module tb_writeback_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic [63:0] retired;
   logic [1:0]  err_sticky;

   int checks   = 0;
   int failures = 0;

   writeback_stage_if #(.XLEN(64)) bus ();

   writeback_stage #(.XLEN(64), .CNT_W(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .bus        (bus),
      .retired    (retired),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        rw;
      logic [4:0]  rd;
      logic [63:0] wd;
      logic        v;
      logic        chk_wd;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic v, input logic rw, input logic [1:0] src,
                          input logic [2:0] f3, input logic [63:0] alu,
                          input logic [63:0] rdata, input logic [63:0] pc4,
                          input logic [4:0] rd);
      bus.mem_valid     = v;
      bus.mem_RegWrite  = rw;
      bus.mem_MemtoReg  = src;
      bus.mem_Funct3    = f3;
      bus.mem_ALUResult = alu;
      bus.mem_ReadData  = rdata;
      bus.mem_PCPlus4   = pc4;
      bus.mem_RD        = rd;
   endtask

   task automatic idle();
      present(1'b0, 1'b0, 2'b00, 3'b000, 64'h0, 64'h0, 64'h0, 5'd0);
   endtask

   task automatic expect_out(input string tag, input logic rw, input logic [4:0] rd,
                             input logic [63:0] wd, input logic v, input logic chk_wd);
      exp_t e;
      e.tag = tag; e.rw = rw; e.rd = rd; e.wd = wd; e.v = v; e.chk_wd = chk_wd;
      sb.push_back(e);
   endtask

   // Advance one posedge, then compare the WB outputs against the oldest expectation.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0)
      else begin
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=entry");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({e.tag, ".RegWrite"}, 64'(bus.RegWrite), 64'(e.rw));
         check({e.tag, ".RD"},       64'(bus.RD),       64'(e.rd));
         check({e.tag, ".wb_valid"}, 64'(bus.wb_valid), 64'(e.v));
         if (e.chk_wd) check({e.tag, ".WriteData"}, bus.WriteData, e.wd);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      idle();
      #12;
      check("reset.RegWrite",   64'(bus.RegWrite),  64'h0);
      check("reset.RD",         64'(bus.RD),        64'h0);
      check("reset.WriteData",  bus.WriteData,      64'h0);
      check("reset.wb_valid",   64'(bus.wb_valid),  64'h0);
      check("reset.retired",    retired,            64'h0);
      check("reset.err_sticky", 64'(err_sticky),    64'h0);
      @(negedge clk);
      reset = 1'b1;

      // ALU writeback, counted one cycle after it appears
      present(1'b1, 1'b1, 2'b00, 3'b000, 64'h1234, 64'h0, 64'h0, 5'd5);
      expect_out("alu", 1'b1, 5'd5, 64'h1234, 1'b1, 1'b1);
      tick();
      check("alu.retired_same_cycle", retired, 64'd0);
      idle();
      expect_out("idle0", 1'b0, 5'd0, 64'h0, 1'b0, 1'b1);
      tick();
      check("alu.retired_next", retired, 64'd1);

      // Signed and unsigned byte loads at offset 3
      present(1'b1, 1'b1, 2'b01, 3'b000, 64'h1003, 64'h0102_0304_8011_2233, 64'h0, 5'd6);
      expect_out("lb", 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b1);
      tick();
      present(1'b1, 1'b1, 2'b01, 3'b100, 64'h1003, 64'h0102_0304_8011_2233, 64'h0, 5'd7);
      expect_out("lbu", 1'b1, 5'd7, 64'h80, 1'b1, 1'b1);
      tick();

      // Misaligned LW suppresses the write; clean LD follows
      present(1'b1, 1'b1, 2'b01, 3'b010, 64'h2002, 64'h1111_2222_3333_4444, 64'h0, 5'd8);
      expect_out("lw_misaligned", 1'b0, 5'd8, 64'h0, 1'b1, 1'b0);
      tick();
      check("lw.err_not_yet", 64'(err_sticky), 64'h0);
      present(1'b1, 1'b1, 2'b01, 3'b011, 64'h3000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 5'd9);
      expect_out("ld", 1'b1, 5'd9, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b1);
      tick();
      check("ld.err_sticky", 64'(err_sticky), 64'h1);

      // Signed halfword and word at aligned non-zero offsets
      present(1'b1, 1'b1, 2'b01, 3'b001, 64'h4006, 64'h8001_0000_0000_0000, 64'h0, 5'd14);
      expect_out("lh", 1'b1, 5'd14, 64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b1);
      tick();
      present(1'b1, 1'b1, 2'b01, 3'b110, 64'h4004, 64'h9000_0001_0000_0000, 64'h0, 5'd15);
      expect_out("lwu", 1'b1, 5'd15, 64'h0000_0000_9000_0001, 1'b1, 1'b1);
      tick();

      // Link value, write to x0, reserved source
      present(1'b1, 1'b1, 2'b10, 3'b000, 64'h55, 64'h0, 64'h8000_0004, 5'd1);
      expect_out("pc4", 1'b1, 5'd1, 64'h8000_0004, 1'b1, 1'b1);
      tick();
      present(1'b1, 1'b1, 2'b00, 3'b000, 64'h55, 64'h0, 64'h0, 5'd0);
      expect_out("x0", 1'b0, 5'd0, 64'h55, 1'b1, 1'b1);
      tick();
      present(1'b1, 1'b1, 2'b11, 3'b000, 64'h66, 64'h0, 64'h0, 5'd10);
      expect_out("rsvd_src", 1'b0, 5'd10, 64'h0, 1'b1, 1'b1);
      tick();
      idle();
      expect_out("idle1", 1'b0, 5'd0, 64'h0, 1'b0, 1'b1);
      tick();
      check("mix.retired", retired, 64'd10);
      check("mix.err_sticky", 64'(err_sticky), 64'h3);

      // Stall three cycles with flush on the second
      present(1'b1, 1'b1, 2'b00, 3'b000, 64'hAAAA, 64'h0, 64'h0, 5'd11);
      expect_out("stall_a", 1'b1, 5'd11, 64'hAAAA, 1'b1, 1'b1);
      tick();
      present(1'b1, 1'b1, 2'b00, 3'b000, 64'hBBBB, 64'h0, 64'h0, 5'd12);
      stall = 1'b1;
      expect_out("stall_hold", 1'b1, 5'd11, 64'hAAAA, 1'b1, 1'b1);
      tick();
      check("stall_hold.retired", retired, 64'd10);
      flush = 1'b1;
      expect_out("stall_flush", 1'b0, 5'd0, 64'h0, 1'b0, 1'b1);
      tick();
      flush = 1'b0;
      expect_out("stall_bubble", 1'b0, 5'd0, 64'h0, 1'b0, 1'b1);
      tick();
      stall = 1'b0;
      idle();
      expect_out("stall_done", 1'b0, 5'd0, 64'h0, 1'b0, 1'b1);
      tick();
      check("stall.retired_once", retired, 64'd11);

      // Asynchronous reset between edges while a write is live
      present(1'b1, 1'b1, 2'b00, 3'b000, 64'h77, 64'h0, 64'h0, 5'd13);
      expect_out("pre_reset", 1'b1, 5'd13, 64'h77, 1'b1, 1'b1);
      tick();
      idle();
      #2;
      reset = 1'b0;
      #1;
      check("async.RegWrite",  64'(bus.RegWrite), 64'h0);
      check("async.WriteData", bus.WriteData,     64'h0);
      check("async.wb_valid",  64'(bus.wb_valid), 64'h0);
      check("async.retired",   retired,           64'h0);
      check("async.err",       64'(err_sticky),   64'h0);
      check("scoreboard_drained", 64'(sb.size()), 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
